// File: rtl/axi_id_compact.sv
// rtl/axi_id_compact.sv - AXI4 ID width compactor with per-direction remap tables

package axi_id_compact_pkg;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [5:0]  atop;
    } slv_aw_t;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [5:0]  atop;
    } mst_aw_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_t;

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] resp;
    } slv_b_t;

    typedef struct packed {
        logic [2:0] id;
        logic [1:0] resp;
    } mst_b_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } slv_ar_t;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } mst_ar_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } slv_r_t;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } mst_r_t;

    typedef struct packed {
        slv_aw_t aw;
        logic    aw_valid;
        w_t      w;
        logic    w_valid;
        logic    b_ready;
        slv_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } slv_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        slv_b_t b;
        logic   b_valid;
        slv_r_t r;
        logic   r_valid;
    } slv_resp_t;

    typedef struct packed {
        mst_aw_t aw;
        logic    aw_valid;
        w_t      w;
        logic    w_valid;
        logic    b_ready;
        mst_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } mst_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        mst_b_t b;
        logic   b_valid;
        mst_r_t r;
        logic   r_valid;
    } mst_resp_t;

endpackage

// One remap table: allocates a compact index per slave ID and counts outstanding bursts.
module axi_id_compact_table #(
    parameter int SlvIdWidth   = 8,
    parameter int MstIdWidth   = 3,
    parameter int MaxTxnsPerId = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid,
    input  logic                  req_ready,
    input  logic [SlvIdWidth-1:0] req_id,
    output logic                  req_grant,
    output logic [MstIdWidth-1:0] req_mst_id,
    input  logic                  rsp_valid,
    input  logic                  rsp_ready,
    input  logic                  rsp_last,
    input  logic [MstIdWidth-1:0] rsp_mst_id,
    output logic [SlvIdWidth-1:0] rsp_slv_id,
    output logic                  busy
);

    localparam int N        = 2 ** MstIdWidth;
    localparam int CntWidth = $clog2(MaxTxnsPerId + 1);

    logic [N-1:0]          used_q;
    logic [SlvIdWidth-1:0] slv_id_q [N];
    logic [CntWidth-1:0]   cnt_q    [N];
    logic                  lock_q;
    logic [MstIdWidth-1:0] lock_idx_q;

    logic                  hit, free;
    logic [MstIdWidth-1:0] hit_idx, free_idx;
    logic                  push, pop;
    logic [N-1:0]          inc_vec, dec_vec;

    // Look up an existing mapping for req_id and the lowest-index free entry.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!used_q[i]) begin
                free     = 1'b1;
                free_idx = MstIdWidth'(i);
            end
            if (used_q[i] && (slv_id_q[i] == req_id)) begin
                hit     = 1'b1;
                hit_idx = MstIdWidth'(i);
            end
        end
    end

    // Grant decision; a locked index overrides the lookup so the master ID stays stable.
    always_comb begin
        if (lock_q) begin
            req_grant  = 1'b1;
            req_mst_id = lock_idx_q;
        end else if (hit) begin
            req_grant  = (cnt_q[hit_idx] < CntWidth'(MaxTxnsPerId));
            req_mst_id = hit_idx;
        end else begin
            req_grant  = free;
            req_mst_id = free_idx;
        end
    end

    assign push       = req_valid && req_ready && req_grant;
    assign pop        = rsp_valid && rsp_ready && rsp_last;
    assign rsp_slv_id = slv_id_q[rsp_mst_id];
    assign busy       = |used_q;

    // Per-entry increment/decrement strobes; a decrement of an empty entry is ignored.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < N; i++) begin
            inc_vec[i] = push && (req_mst_id == MstIdWidth'(i));
            dec_vec[i] = pop && (rsp_mst_id == MstIdWidth'(i)) && (cnt_q[i] != '0);
        end
    end

    // Table update; simultaneous inc and dec on one entry cancel and keep it used.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            used_q <= '0;
            for (int i = 0; i < N; i++) begin
                slv_id_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt_q[i] <= cnt_q[i] + CntWidth'(1);
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    cnt_q[i] <= cnt_q[i] - CntWidth'(1);
                end
                if (inc_vec[i]) begin
                    used_q[i]   <= 1'b1;
                    slv_id_q[i] <= req_id;
                end else if (dec_vec[i] && (cnt_q[i] == CntWidth'(1))) begin
                    used_q[i] <= 1'b0;
                end
            end
        end
    end

    // Hold the presented index from the first granted valid cycle until the handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (!req_valid || push) begin
            lock_q <= 1'b0;
        end else if (req_grant && !lock_q) begin
            lock_q     <= 1'b1;
            lock_idx_q <= req_mst_id;
        end
    end

    rsp_for_live_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rsp_valid && rsp_ready) |-> (used_q[rsp_mst_id] && (cnt_q[rsp_mst_id] != '0)));

endmodule

// Top level: remaps AW/B through the write table and AR/R through the read table.
module axi_id_compact #(
    parameter int  SlvIdWidth   = 8,
    parameter int  MstIdWidth   = 3,
    parameter int  MaxTxnsPerId = 4,
    parameter type slv_req_t    = axi_id_compact_pkg::slv_req_t,
    parameter type slv_resp_t   = axi_id_compact_pkg::slv_resp_t,
    parameter type mst_req_t    = axi_id_compact_pkg::mst_req_t,
    parameter type mst_resp_t   = axi_id_compact_pkg::mst_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  slv_req_t  slv_req_i,
    output slv_resp_t slv_resp_o,
    output mst_req_t  mst_req_o,
    input  mst_resp_t mst_resp_i,
    output logic      wr_busy_o,
    output logic      rd_busy_o
);

    logic                  wr_grant, rd_grant;
    logic [MstIdWidth-1:0] wr_mst_id, rd_mst_id;
    logic [SlvIdWidth-1:0] wr_slv_id, rd_slv_id;

    axi_id_compact_table #(
        .SlvIdWidth  (SlvIdWidth),
        .MstIdWidth  (MstIdWidth),
        .MaxTxnsPerId(MaxTxnsPerId)
    ) i_wr_table (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_valid (slv_req_i.aw_valid),
        .req_ready (mst_resp_i.aw_ready),
        .req_id    (slv_req_i.aw.id),
        .req_grant (wr_grant),
        .req_mst_id(wr_mst_id),
        .rsp_valid (mst_resp_i.b_valid),
        .rsp_ready (slv_req_i.b_ready),
        .rsp_last  (1'b1),
        .rsp_mst_id(mst_resp_i.b.id),
        .rsp_slv_id(wr_slv_id),
        .busy      (wr_busy_o)
    );

    axi_id_compact_table #(
        .SlvIdWidth  (SlvIdWidth),
        .MstIdWidth  (MstIdWidth),
        .MaxTxnsPerId(MaxTxnsPerId)
    ) i_rd_table (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_valid (slv_req_i.ar_valid),
        .req_ready (mst_resp_i.ar_ready),
        .req_id    (slv_req_i.ar.id),
        .req_grant (rd_grant),
        .req_mst_id(rd_mst_id),
        .rsp_valid (mst_resp_i.r_valid),
        .rsp_ready (slv_req_i.r_ready),
        .rsp_last  (mst_resp_i.r.last),
        .rsp_mst_id(mst_resp_i.r.id),
        .rsp_slv_id(rd_slv_id),
        .busy      (rd_busy_o)
    );

    // Zero-latency pass-through with ID substitution and grant gating of AW/AR.
    always_comb begin
        mst_req_o  = '0;
        slv_resp_o = '0;

        mst_req_o.aw.id      = wr_mst_id;
        mst_req_o.aw.addr    = slv_req_i.aw.addr;
        mst_req_o.aw.len     = slv_req_i.aw.len;
        mst_req_o.aw.atop    = slv_req_i.aw.atop;
        mst_req_o.aw_valid   = slv_req_i.aw_valid && wr_grant;
        mst_req_o.w          = slv_req_i.w;
        mst_req_o.w_valid    = slv_req_i.w_valid;
        mst_req_o.b_ready    = slv_req_i.b_ready;
        mst_req_o.ar.id      = rd_mst_id;
        mst_req_o.ar.addr    = slv_req_i.ar.addr;
        mst_req_o.ar.len     = slv_req_i.ar.len;
        mst_req_o.ar_valid   = slv_req_i.ar_valid && rd_grant;
        mst_req_o.r_ready    = slv_req_i.r_ready;

        slv_resp_o.aw_ready  = mst_resp_i.aw_ready && wr_grant;
        slv_resp_o.ar_ready  = mst_resp_i.ar_ready && rd_grant;
        slv_resp_o.w_ready   = mst_resp_i.w_ready;
        slv_resp_o.b.id      = wr_slv_id;
        slv_resp_o.b.resp    = mst_resp_i.b.resp;
        slv_resp_o.b_valid   = mst_resp_i.b_valid;
        slv_resp_o.r.id      = rd_slv_id;
        slv_resp_o.r.data    = mst_resp_i.r.data;
        slv_resp_o.r.resp    = mst_resp_i.r.resp;
        slv_resp_o.r.last    = mst_resp_i.r.last;
        slv_resp_o.r_valid   = mst_resp_i.r_valid;
    end

    atop_with_r_unsupported: assert property (@(posedge clk_i) disable iff (!rst_ni)
        slv_req_i.aw_valid |-> !slv_req_i.aw.atop[5]);

endmodule

// File: tb/tb_axi_id_compact.sv
// tb/tb_axi_id_compact.sv - self-checking bench for axi_id_compact

module tb_axi_id_compact;

    import axi_id_compact_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    slv_req_t  slv_req;
    slv_resp_t slv_resp;
    mst_req_t  mst_req;
    mst_resp_t mst_resp;
    logic      wr_busy, rd_busy;

    int n_vec = 0;
    int n_err = 0;

    axi_id_compact dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .slv_req_i (slv_req),
        .slv_resp_o(slv_resp),
        .mst_req_o (mst_req),
        .mst_resp_i(mst_resp),
        .wr_busy_o (wr_busy),
        .rd_busy_o (rd_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit aw_v;
        int aw_id;
        bit b_v;
        int b_id;
        bit e_awv;
        int e_awid;
        bit e_awrdy;
        int e_bid;
        bit e_busy;
    } vec_t;

    typedef struct {
        int idx;
        int sid;
    } ot_t;

    vec_t vecs[$];
    ot_t  ot[$];

    function automatic vec_t mk(bit aw_v, int aw_id, bit b_v, int b_id,
                                bit e_awv, int e_awid, bit e_awrdy, int e_bid, bit e_busy);
        vec_t v;
        v.aw_v = aw_v; v.aw_id = aw_id; v.b_v = b_v; v.b_id = b_id;
        v.e_awv = e_awv; v.e_awid = e_awid; v.e_awrdy = e_awrdy;
        v.e_bid = e_bid; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        slv_req.aw_valid  = 1'b0;
        slv_req.aw.id     = '0;
        slv_req.aw.atop   = '0;
        slv_req.ar_valid  = 1'b0;
        slv_req.ar.id     = '0;
        slv_req.w_valid   = 1'b0;
        slv_req.b_ready   = 1'b1;
        slv_req.r_ready   = 1'b1;
        mst_resp.aw_ready = 1'b1;
        mst_resp.ar_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        mst_resp.b_valid  = 1'b0;
        mst_resp.b.id     = '0;
        mst_resp.r_valid  = 1'b0;
        mst_resp.r.id     = '0;
        mst_resp.r.last   = 1'b0;
    endtask

    // Reference allocation rule over the set of outstanding write bursts.
    function automatic void predict(input int sid, output bit g, output int idx);
        int cnt = 0;
        bit found = 0;
        g = 0;
        idx = 0;
        foreach (ot[k]) begin
            if (ot[k].sid == sid) begin
                found = 1;
                idx = ot[k].idx;
                cnt++;
            end
        end
        if (found) begin
            g = (cnt < 4);
            return;
        end
        for (int i = 0; i < 8; i++) begin
            bit taken = 0;
            foreach (ot[k]) if (ot[k].idx == i) taken = 1;
            if (!taken) begin
                g = 1;
                idx = i;
                return;
            end
        end
    endfunction

    function automatic int sid_of(input int idx);
        foreach (ot[k]) if (ot[k].idx == idx) return ot[k].sid;
        return -1;
    endfunction

    initial begin
        slv_req  = '0;
        mst_resp = '0;
        idle();

        // Reset state and pass-through during reset
        slv_req.w.data  = 32'hCAFE_F00D;
        mst_resp.b.resp = 2'b10;
        tick();
        tick();
        #2;
        chk("rst_wr_busy", int'(wr_busy), 0);
        chk("rst_rd_busy", int'(rd_busy), 0);
        chk("rst_w_data", int'(mst_req.w.data), int'(32'hCAFE_F00D));
        chk("rst_b_resp", int'(slv_resp.b.resp), 2);
        rst_n = 1'b1;
        tick();

        // Write-path table: single-ID, multi-ID, same-cycle inc/dec, per-ID limit
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h5A, 0, 0, 1, 0, 1, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h5A, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h10, 0, 0, 1, 0, 1, 8'h00, 0));
        vecs.push_back(mk(1, 8'h20, 0, 0, 1, 1, 1, 8'h00, 1));
        vecs.push_back(mk(1, 8'h10, 0, 0, 1, 0, 1, 8'h00, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h10, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 8'h20, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h10, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h33, 0, 0, 1, 0, 1, 8'h00, 0));
        vecs.push_back(mk(1, 8'h33, 1, 0, 1, 0, 1, 8'h33, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h33, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h44, 0, 0, 1, 0, 1, 8'h00, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 8'h44, 0, 0, 1, 0, 1, 8'h00, 1));
        vecs.push_back(mk(1, 8'h44, 0, 0, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(1, 8'h44, 1, 0, 0, 0, 0, 8'h44, 1));
        vecs.push_back(mk(1, 8'h44, 0, 0, 1, 0, 1, 8'h00, 1));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h44, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0));

        foreach (vecs[i]) begin
            idle();
            slv_req.aw_valid = vecs[i].aw_v;
            slv_req.aw.id    = 8'(vecs[i].aw_id);
            mst_resp.b_valid = vecs[i].b_v;
            mst_resp.b.id    = 3'(vecs[i].b_id);
            #2;
            chk($sformatf("v%0d_aw_valid", i), int'(mst_req.aw_valid), int'(vecs[i].e_awv));
            if (vecs[i].e_awv) chk($sformatf("v%0d_aw_id", i), int'(mst_req.aw.id), vecs[i].e_awid);
            if (vecs[i].aw_v) chk($sformatf("v%0d_aw_ready", i), int'(slv_resp.aw_ready), int'(vecs[i].e_awrdy));
            if (vecs[i].b_v) chk($sformatf("v%0d_b_id", i), int'(slv_resp.b.id), vecs[i].e_bid);
            chk($sformatf("v%0d_wr_busy", i), int'(wr_busy), int'(vecs[i].e_busy));
            tick();
        end

        // Locked AW index survives a free of a lower entry
        idle(); slv_req.aw_valid = 1; slv_req.aw.id = 8'h11; #2;
        chk("lock_aw0_id", int'(mst_req.aw.id), 0); tick();
        slv_req.aw.id = 8'h22; #2;
        chk("lock_aw1_id", int'(mst_req.aw.id), 1); tick();
        slv_req.aw.id = 8'h33; mst_resp.aw_ready = 0; #2;
        chk("lock_pend_valid", int'(mst_req.aw_valid), 1);
        chk("lock_pend_id", int'(mst_req.aw.id), 2);
        chk("lock_pend_ready", int'(slv_resp.aw_ready), 0); tick();
        mst_resp.b_valid = 1; mst_resp.b.id = 0; #2;
        chk("lock_free_id", int'(mst_req.aw.id), 2);
        chk("lock_free_bid", int'(slv_resp.b.id), 8'h11); tick();
        mst_resp.b_valid = 0; #2;
        chk("lock_after_free_id", int'(mst_req.aw.id), 2); tick();
        mst_resp.aw_ready = 1; #2;
        chk("lock_hs_id", int'(mst_req.aw.id), 2);
        chk("lock_hs_ready", int'(slv_resp.aw_ready), 1); tick();
        idle(); mst_resp.b_valid = 1; mst_resp.b.id = 1; #2;
        chk("lock_drain_b1", int'(slv_resp.b.id), 8'h22); tick();
        mst_resp.b.id = 2; #2;
        chk("lock_drain_b2", int'(slv_resp.b.id), 8'h33); tick();
        idle(); #2;
        chk("lock_wr_busy", int'(wr_busy), 0); tick();

        // Read table full: ninth distinct ID waits for a freed index
        for (int k = 0; k < 8; k++) begin
            idle(); slv_req.ar_valid = 1; slv_req.ar.id = 8'(8'h80 + k); #2;
            chk($sformatf("full_ar%0d_id", k), int'(mst_req.ar.id), k); tick();
        end
        slv_req.ar.id = 8'h99; mst_resp.r_valid = 1; mst_resp.r.id = 3; mst_resp.r.last = 1; #2;
        chk("full_stall_valid", int'(mst_req.ar_valid), 0);
        chk("full_stall_ready", int'(slv_resp.ar_ready), 0);
        chk("full_r_id", int'(slv_resp.r.id), 8'h83); tick();
        mst_resp.r_valid = 0; #2;
        chk("full_grant_valid", int'(mst_req.ar_valid), 1);
        chk("full_grant_id", int'(mst_req.ar.id), 3);
        chk("full_grant_ready", int'(slv_resp.ar_ready), 1); tick();
        for (int k = 0; k < 8; k++) begin
            idle(); mst_resp.r_valid = 1; mst_resp.r.id = 3'(k); mst_resp.r.last = 1; #2;
            chk($sformatf("full_drain%0d", k), int'(slv_resp.r.id), (k == 3) ? 8'h99 : 8'h80 + k); tick();
        end
        idle(); #2;
        chk("full_rd_busy", int'(rd_busy), 0); tick();

        // Per-ID limit on reads: only the last beat releases a slot
        for (int k = 0; k < 4; k++) begin
            idle(); slv_req.ar_valid = 1; slv_req.ar.id = 8'h07; #2;
            chk($sformatf("lim_ar%0d_id", k), int'(mst_req.ar.id), 0); tick();
        end
        for (int b = 0; b < 3; b++) begin
            mst_resp.r_valid = 1; mst_resp.r.id = 0; mst_resp.r.last = (b == 2); #2;
            chk($sformatf("lim_stall%0d", b), int'(mst_req.ar_valid), 0);
            chk($sformatf("lim_rid%0d", b), int'(slv_resp.r.id), 8'h07); tick();
        end
        mst_resp.r_valid = 0; mst_resp.r.last = 0; #2;
        chk("lim_grant_valid", int'(mst_req.ar_valid), 1);
        chk("lim_grant_id", int'(mst_req.ar.id), 0); tick();
        for (int k = 0; k < 4; k++) begin
            idle(); mst_resp.r_valid = 1; mst_resp.r.id = 0; mst_resp.r.last = 1; #2;
            chk($sformatf("lim_drain%0d", k), int'(slv_resp.r.id), 8'h07); tick();
        end
        idle(); #2;
        chk("lim_rd_busy", int'(rd_busy), 0); tick();

        // Asynchronous reset mid-burst clears both tables at once
        slv_req.aw_valid = 1; slv_req.aw.id = 8'h55;
        slv_req.ar_valid = 1; slv_req.ar.id = 8'h66; tick();
        idle(); #2;
        chk("rstmid_wr_busy_pre", int'(wr_busy), 1);
        chk("rstmid_rd_busy_pre", int'(rd_busy), 1);
        rst_n = 0; #1;
        chk("rstmid_wr_busy", int'(wr_busy), 0);
        chk("rstmid_rd_busy", int'(rd_busy), 0);
        tick();
        rst_n = 1;
        tick();

        // Random write traffic against the outstanding-set model
        begin
            bit pend = 0, lk = 0, g, bv, hs;
            int pid = 0, lk_idx = 0, idx, k, bidx, are;
            for (int cyc = 0; cyc < 600; cyc++) begin
                idle();
                if (!pend && ($urandom_range(1, 0) == 1)) begin
                    pend = 1;
                    pid = $urandom_range(11, 0);
                end
                are = $urandom_range(1, 0);
                slv_req.aw_valid  = pend;
                slv_req.aw.id     = 8'(pid);
                mst_resp.aw_ready = are[0];
                bv = (ot.size() > 0) && ($urandom_range(2, 0) != 0);
                k = 0; bidx = 0;
                if (bv) begin
                    k = $urandom_range(ot.size() - 1, 0);
                    bidx = ot[k].idx;
                end
                mst_resp.b_valid = bv;
                mst_resp.b.id    = 3'(bidx);
                if (lk) begin
                    g = 1;
                    idx = lk_idx;
                end else begin
                    predict(pid, g, idx);
                end
                #2;
                chk("rnd_aw_valid", int'(mst_req.aw_valid), int'(pend && g));
                if (pend && g) chk("rnd_aw_id", int'(mst_req.aw.id), idx);
                if (pend) chk("rnd_aw_ready", int'(slv_resp.aw_ready), int'(g && are[0]));
                if (bv) chk("rnd_b_id", int'(slv_resp.b.id), sid_of(bidx));
                chk("rnd_wr_busy", int'(wr_busy), int'(ot.size() > 0));
                hs = pend && g && are[0];
                if (bv) ot.delete(k);
                if (hs) begin
                    ot.push_back('{idx: idx, sid: pid});
                    pend = 0;
                    lk = 0;
                end else if (pend && g) begin
                    lk = 1;
                    lk_idx = idx;
                end
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_id_compact.md
AXI_ID_COMPACT -- requirements
Module: axi_id_compact

Interface
REQ-001 SHALL have parameter SlvIdWidth, default 8: slave-port ID width (bits).
REQ-002 SHALL have parameter MstIdWidth, default 3: master-port ID width (bits); table size N = 2**MstIdWidth entries per direction.
REQ-003 SHALL have parameter MaxTxnsPerId, default 4: maximum outstanding transactions per table entry.
REQ-004 SHALL have type parameters slv_req_t, slv_resp_t, mst_req_t and mst_resp_t: AXI4 request/response structs per port; all fields other than ID are identical between ports.
REQ-005 SHALL have port clk_i, input, 1: clock.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port slv_req_i, input, slv_req_t: slave-port request.
REQ-008 SHALL have port slv_resp_o, output, slv_resp_t: slave-port response.
REQ-009 SHALL have port mst_req_o, output, mst_req_t: master-port request.
REQ-010 SHALL have port mst_resp_i, input, mst_resp_t: master-port response.
REQ-011 SHALL have port wr_busy_o, output, 1: at least one write-table entry in use.
REQ-012 SHALL have port rd_busy_o, output, 1: at least one read-table entry in use.

Function
REQ-013 SHALL keep two independent tables, write (AW/B) and read (AR/R); entry i holds {used, slv_id, cnt}, with cnt from 0 to MaxTxnsPerId.
REQ-014 SHALL, on an AW request, select the used entry whose slv_id equals aw.id if one exists ("hit"); otherwise select the lowest-index unused entry; it SHALL grant only if the selected entry has cnt < MaxTxnsPerId.
REQ-015 SHALL stall the request when there is no hit and no free entry, or when the hit entry has cnt == MaxTxnsPerId: mst aw_valid=0 and slv aw_ready=0.
REQ-016 SHALL, when granted, drive mst aw_valid = slv aw_valid and slv aw_ready = mst aw_ready, combinationally with zero latency; grant SHALL NOT depend on aw_ready.
REQ-017 SHALL drive mst aw.id = selected entry index; all other AW fields SHALL pass through unchanged.
REQ-018 SHALL, once mst aw_valid rises, lock the selected index in a register until the handshake, so that aw.id stays stable even if entries are freed meanwhile.
REQ-019 SHALL, on the AW handshake, set used=1, write slv_id (on a miss) and increment cnt.
REQ-020 SHALL pass W through unchanged with zero latency.
REQ-021 SHALL drive slv b.id = write_table[mst b.id].slv_id; all other B signals SHALL pass through unchanged.
REQ-022 SHALL, on a B handshake, decrement that entry's cnt and clear used when cnt reaches 0.
REQ-023 SHALL handle AR/R identically to REQ-014..REQ-022 using the read table; it SHALL decrement only on an R handshake with r.last=1 and map r.id on every beat.
REQ-024 SHALL, when an increment and a decrement hit the same entry in one cycle, leave cnt unchanged and keep used=1.
REQ-025 SHALL allow a B/R decrement and an AW/AR allocation to be visible only from the next cycle; a free caused in cycle t SHALL NOT grant in cycle t.
REQ-026 SHALL treat an AW with atop[5]=1 (ATOP with R response) as unsupported: a simulation assertion SHALL fire; behaviour is undefined.
REQ-027 SHALL have a simulation assertion that fires on any B or R received for an entry with used=0 or cnt=0.
REQ-028 SHALL drive wr_busy_o/rd_busy_o = OR of the used bits of each table, combinationally.

Reset
REQ-029 SHALL, while rst_ni=0, clear all used bits, cnt fields and lock registers to 0 asynchronously.
REQ-030 SHALL have wr_busy_o=0 and rd_busy_o=0 after reset; the combinational pass-through outputs SHALL follow their inputs.
REQ-031 SHALL NOT guarantee transactions in flight at reset; responses to them are protocol violations upstream.

Verification
REQ-032 SHALL be verified as follows: AW id 0x5A on an empty table -> mst aw.id=0, same cycle; B id 0 -> slv b.id=0x5A, wr_busy_o falls the next cycle.
REQ-033 SHALL be verified as follows: AW ids 0x10, 0x20, 0x10 -> mst ids 0, 1, 0; entry 0 cnt=2; entry 0 stays used until two Bs are received.
REQ-034 SHALL be verified as follows (MstIdWidth=3): 8 distinct AR ids outstanding, 9th distinct id -> stalled with ar_ready=0; R last on id 3 -> 9th granted next cycle as id 3.
REQ-035 SHALL be verified as follows: 4 ARs with id 0x7 outstanding, 5th -> stalled; multi-beat R on id 0 -> cnt decrements only on last, and the 5th is granted the cycle after.
REQ-036 SHALL be verified as follows: AW pending on index 2 with aw_ready=0, B frees index 0 -> aw.id stays 2 until the handshake.
REQ-037 SHALL be verified as follows: same-cycle AW handshake hit and B on the same entry -> cnt unchanged; rst_ni pulsed low mid-burst -> busy outputs drop to 0 immediately.
